mpu_host_cmd_tx: RTL and testbench

//  Host-side command transmitter for the MPU external interface. Accepts one high-level

---
 rtl/mpu_host_cmd_tx.sv | 205 ++++++++++++++++++++
 tb/tb_mpu_host_cmd_tx.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_host_cmd_tx.sv
// Host-side MPU command transmitter: serialises one command into MPU
// interface words, streams payload to/from the MPU and tracks MPU status.
module mpu_host_cmd_tx #(
    parameter int DATA_W  = 32,
    parameter int NUM_TPU = 16,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               I_Cmd_Valid,
    input  logic [2:0]         I_Cmd_Op,
    input  logic [DATA_W-1:0]  I_Cmd_ID,
    input  logic [DATA_W-1:0]  I_Cmd_Stride,
    input  logic [DATA_W-1:0]  I_Cmd_Base,
    input  logic [LEN_W-1:0]   I_Cmd_Len,
    input  logic [NUM_TPU-1:0] I_Cmd_EnTPU,
    output logic               O_Cmd_Ready,
    input  logic               I_Src_Valid,
    input  logic [DATA_W-1:0]  I_Src_Data,
    output logic               O_Src_Ready,
    input  logic               I_Rsp_Valid,
    input  logic [DATA_W-1:0]  I_Rsp_Data,
    output logic               O_Snk_Valid,
    output logic [DATA_W-1:0]  O_Snk_Data,
    output logic               O_Req_IF,
    output logic [DATA_W-1:0]  O_Data_IF,
    output logic               O_End_Ld,
    output logic               O_End_St,
    input  logic [3:0]         I_State,
    output logic               O_Done,
    output logic               O_Err
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] OP_RUN     = 3'd0;
    localparam logic [2:0] OP_ST_PROG = 3'd1;
    localparam logic [2:0] OP_ST_DATA = 3'd2;
    localparam logic [2:0] OP_LD_DATA = 3'd3;
    localparam logic [2:0] OP_STOP    = 3'd4;
    localparam logic [2:0] OP_SET_EN  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ID, S_STRIDE, S_BASE, S_EN,
        S_SRC, S_RSP, S_WRUN, S_WSTOP, S_WRDY
    } state_t;

    state_t             state, state_n;
    logic [2:0]         op;
    logic [DATA_W-1:0]  id, stride, base;
    logic [LEN_W-1:0]   len, cnt;
    logic [NUM_TPU-1:0] en;
    logic [TW-1:0]      wcnt;
    logic               done_n, err_n, end_ld_n;
    logic               accept, last, tmo, rsp_take, waiting;

    assign accept      = (state == S_IDLE) && I_Cmd_Valid;
    assign last        = (cnt == len - LEN_W'(1));
    assign tmo         = (wcnt == TW'(TIMEOUT - 1));
    assign rsp_take    = (state == S_RSP) && (len != '0) && I_Rsp_Valid;
    assign waiting     = (state == S_WRUN) || (state == S_WSTOP) || (state == S_WRDY);
    assign O_Cmd_Ready = (state == S_IDLE);

    always_comb begin
        state_n     = state;
        done_n      = 1'b0;
        err_n       = 1'b0;
        end_ld_n    = 1'b0;
        O_Req_IF    = 1'b0;
        O_Data_IF   = '0;
        O_Src_Ready = 1'b0;
        O_End_St    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (I_Cmd_Valid) begin
                    if (I_Cmd_Op > OP_SET_EN) err_n = 1'b1;
                    else                      state_n = S_CMD;
                end
            end
            S_CMD: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = DATA_W'(6'b000001 << op);
                case (op)
                    OP_RUN, OP_ST_DATA, OP_LD_DATA: state_n = S_ID;
                    OP_ST_PROG: state_n = S_SRC;
                    OP_STOP:    state_n = S_WSTOP;
                    OP_SET_EN:  state_n = S_EN;
                    default:    state_n = S_IDLE;
                endcase
            end
            S_ID: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = id;
                state_n   = (op == OP_RUN) ? S_WRUN : S_STRIDE;
            end
            S_STRIDE: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = stride;
                state_n   = S_BASE;
            end
            S_BASE: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = base;
                state_n   = (op == OP_LD_DATA) ? S_RSP : S_SRC;
            end
            S_EN: begin
                O_Req_IF  = 1'b1;
                O_Data_IF = DATA_W'(en);
                done_n    = 1'b1;
                state_n   = S_IDLE;
            end
            S_SRC: begin
                // An empty payload still spends one cycle here to flag the end
                if (len == '0) begin
                    O_End_St = 1'b1;
                    state_n  = S_WRDY;
                end else if (I_Src_Valid) begin
                    O_Req_IF    = 1'b1;
                    O_Data_IF   = I_Src_Data;
                    O_Src_Ready = 1'b1;
                    if (last) begin
                        O_End_St = 1'b1;
                        state_n  = S_WRDY;
                    end
                end
            end
            S_RSP: begin
                if (len == '0 || (I_Rsp_Valid && last)) begin
                    end_ld_n = 1'b1;
                    state_n  = S_WRDY;
                end
            end
            S_WRUN: begin
                if (I_State[1]) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WSTOP: begin
                if (I_State[2]) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WRDY: begin
                // NoThMem outranks Ready
                if (I_State[3] || (!I_State[0] && tmo)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else if (I_State[0]) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            op          <= '0;
            id          <= '0;
            stride      <= '0;
            base        <= '0;
            len         <= '0;
            en          <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            O_Done      <= 1'b0;
            O_Err       <= 1'b0;
            O_End_Ld    <= 1'b0;
            O_Snk_Valid <= 1'b0;
            O_Snk_Data  <= '0;
        end else begin
            state       <= state_n;
            O_Done      <= done_n;
            O_Err       <= err_n;
            O_End_Ld    <= end_ld_n;
            O_Snk_Valid <= rsp_take;
            if (rsp_take) O_Snk_Data <= I_Rsp_Data;
            if (accept) begin
                op     <= I_Cmd_Op;
                id     <= I_Cmd_ID;
                stride <= I_Cmd_Stride;
                base   <= I_Cmd_Base;
                len    <= I_Cmd_Len;
                en     <= I_Cmd_EnTPU;
                cnt    <= '0;
            end else if (O_Src_Ready || rsp_take) begin
                cnt <= cnt + LEN_W'(1);
            end
            if (state_n != state) wcnt <= '0;
            else if (waiting)     wcnt <= wcnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_mpu_host_cmd_tx.sv
// Randomised bench for mpu_host_cmd_tx with a transaction-level model:
// expected MPU words, forwarded load words and per-command outcome.
module tb_mpu_host_cmd_tx;

    localparam int DW = 32;
    localparam int NT = 16;
    localparam int LW = 16;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          I_Cmd_Valid = 1'b0;
    logic [2:0]    I_Cmd_Op = '0;
    logic [DW-1:0] I_Cmd_ID = '0;
    logic [DW-1:0] I_Cmd_Stride = '0;
    logic [DW-1:0] I_Cmd_Base = '0;
    logic [LW-1:0] I_Cmd_Len = '0;
    logic [NT-1:0] I_Cmd_EnTPU = '0;
    logic          O_Cmd_Ready;
    logic          I_Src_Valid = 1'b0;
    logic [DW-1:0] I_Src_Data = '0;
    logic          O_Src_Ready;
    logic          I_Rsp_Valid = 1'b0;
    logic [DW-1:0] I_Rsp_Data = '0;
    logic          O_Snk_Valid;
    logic [DW-1:0] O_Snk_Data;
    logic          O_Req_IF;
    logic [DW-1:0] O_Data_IF;
    logic          O_End_Ld;
    logic          O_End_St;
    logic [3:0]    I_State = '0;
    logic          O_Done;
    logic          O_Err;

    mpu_host_cmd_tx #(
        .DATA_W(DW), .NUM_TPU(NT), .LEN_W(LW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .I_Cmd_Valid(I_Cmd_Valid), .I_Cmd_Op(I_Cmd_Op),
        .I_Cmd_ID(I_Cmd_ID), .I_Cmd_Stride(I_Cmd_Stride),
        .I_Cmd_Base(I_Cmd_Base), .I_Cmd_Len(I_Cmd_Len),
        .I_Cmd_EnTPU(I_Cmd_EnTPU), .O_Cmd_Ready(O_Cmd_Ready),
        .I_Src_Valid(I_Src_Valid), .I_Src_Data(I_Src_Data),
        .O_Src_Ready(O_Src_Ready),
        .I_Rsp_Valid(I_Rsp_Valid), .I_Rsp_Data(I_Rsp_Data),
        .O_Snk_Valid(O_Snk_Valid), .O_Snk_Data(O_Snk_Data),
        .O_Req_IF(O_Req_IF), .O_Data_IF(O_Data_IF),
        .O_End_Ld(O_End_Ld), .O_End_St(O_End_St),
        .I_State(I_State), .O_Done(O_Done), .O_Err(O_Err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen, err_seen, end_st_seen, end_ld_seen;
    int last_req_cyc, err_cyc, done_cyc;
    logic [DW-1:0] endst_word;
    logic [DW-1:0] wq[$];
    logic [DW-1:0] sq[$];
    logic [DW-1:0] obs[$];
    logic [DW-1:0] snk_obs[$];
    logic [DW-1:0] e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clock) begin
        if (!reset) begin
            wq.delete();
            sq.delete();
        end else begin
            if (O_Req_IF) begin
                obs.push_back(O_Data_IF);
                last_req_cyc = cyc;
                if (wq.size() == 0) bad("unexpected_word");
                else begin
                    e = wq.pop_front();
                    chk("mpu_word", O_Data_IF, e);
                end
            end else begin
                chk("data_idle_zero", O_Data_IF, 0);
            end
            if (O_End_St) begin
                end_st_seen++;
                endst_word = O_Data_IF;
                chk("end_st_on_last", wq.size(), 0);
            end
            if (O_Snk_Valid) begin
                snk_obs.push_back(O_Snk_Data);
                if (sq.size() == 0) bad("unexpected_snk");
                else begin
                    e = sq.pop_front();
                    chk("snk_word", O_Snk_Data, e);
                end
            end
            if (O_End_Ld) begin
                end_ld_seen++;
                chk("end_ld_after_last", sq.size(), 0);
            end
            if (O_Done || O_Err) begin
                chk("ready_at_end", O_Cmd_Ready, 1);
                chk("words_left_at_end", wq.size(), 0);
            end
            if (O_Done) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (O_Err) begin
                err_seen++;
                err_cyc = cyc;
            end
            chk("done_err_excl", O_Done & O_Err, 0);
        end
    end

    function automatic logic exp_ok(input logic [2:0] op, input logic [3:0] st);
        case (op)
            3'd0:             return st[1];
            3'd4:             return st[2];
            3'd5:             return 1'b1;
            3'd1, 3'd2, 3'd3: return !st[3] && st[0];
            default:          return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_src(input logic [DW-1:0] w);
        logic r;
        int k;
        I_Src_Valid = 1'b1;
        I_Src_Data  = w;
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            r = O_Src_Ready;
            tick();
            if (r) break;
        end
        if (k == 100) bad("src_stall_bound");
        I_Src_Valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [DW-1:0] id,
                         input logic [DW-1:0] stride, input logic [DW-1:0] base,
                         input int len, input logic [NT-1:0] en,
                         input logic [3:0] st, input bit lit);
        logic [DW-1:0] pay[$];
        logic [DW-1:0] w;
        logic ok;
        int k;
        done_seen = 0; err_seen = 0; end_st_seen = 0; end_ld_seen = 0;
        obs.delete();
        snk_obs.delete();
        chk("ready_before_cmd", O_Cmd_Ready, 1);
        if (op <= 3'd5) wq.push_back(32'd1 << op);
        if (op == 3'd0) wq.push_back(id);
        if (op == 3'd2 || op == 3'd3) begin
            wq.push_back(id);
            wq.push_back(stride);
            wq.push_back(base);
        end
        if (op == 3'd5) wq.push_back({16'h0, en});
        for (int i = 0; i < len; i++) begin
            w = lit ? 32'h11 * (i + 1) : $urandom;
            pay.push_back(w);
            if (op == 3'd1 || op == 3'd2) wq.push_back(w);
            if (op == 3'd3) sq.push_back(w);
        end
        I_State      = st;
        I_Cmd_Valid  = 1'b1;
        I_Cmd_Op     = op;
        I_Cmd_ID     = id;
        I_Cmd_Stride = stride;
        I_Cmd_Base   = base;
        I_Cmd_Len    = LW'(len);
        I_Cmd_EnTPU  = en;
        tick();
        I_Cmd_Valid  = 1'b0;
        I_Cmd_Op     = 3'($urandom);
        I_Cmd_ID     = $urandom;
        I_Cmd_Len    = LW'($urandom);
        I_Cmd_EnTPU  = NT'($urandom);
        I_Rsp_Valid  = 1'b1;
        I_Rsp_Data   = 32'hDEAD_BEEF;
        tick();
        I_Rsp_Valid  = 1'b0;
        if (op == 3'd1 || op == 3'd2) begin
            foreach (pay[i]) begin
                repeat ($urandom_range(0, 2)) tick();
                send_src(pay[i]);
            end
        end
        if (op == 3'd3) begin
            for (k = 0; k < 50; k++) begin
                if (wq.size() == 0) break;
                tick();
            end
            if (k == 50) bad("ld_header_bound");
            foreach (pay[i]) begin
                repeat ($urandom_range(0, 2)) tick();
                I_Rsp_Valid = 1'b1;
                I_Rsp_Data  = pay[i];
                tick();
                I_Rsp_Valid = 1'b0;
            end
            repeat (2) begin
                I_Rsp_Valid = 1'b1;
                I_Rsp_Data  = $urandom;
                tick();
            end
            I_Rsp_Valid = 1'b0;
        end
        for (k = 0; k < 300; k++) begin
            if (done_seen + err_seen > 0) break;
            tick();
        end
        if (k == 300) bad("completion_bound");
        repeat (2) tick();
        ok = exp_ok(op, st);
        chk("done_count", done_seen, {63'd0, ok});
        chk("err_count", err_seen, {63'd0, !ok});
        chk("end_st_count", end_st_seen, (op == 3'd1 || op == 3'd2) ? 1 : 0);
        chk("end_ld_count", end_ld_seen, (op == 3'd3) ? 1 : 0);
        chk("words_unsent", wq.size(), 0);
        chk("loads_unforwarded", sq.size(), 0);
        I_State = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] stc [7];
        stc = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0000, 4'b0111};
        #2 reset = 1'b0;
        #10;
        chk("rst_cmd_ready", O_Cmd_Ready, 1);
        chk("rst_req", O_Req_IF, 0);
        chk("rst_data", O_Data_IF, 0);
        chk("rst_done_err", {O_Done, O_Err}, 0);
        chk("rst_end", {O_End_Ld, O_End_St}, 0);
        chk("rst_snk", {O_Snk_Valid, O_Snk_Data}, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        tick();

        // SET_EN: two words then Done the following cycle
        issue(3'd5, 0, 0, 0, 0, 16'hA5A5, 4'b0000, 1'b0);
        chk("seten_nwords", obs.size(), 2);
        chk("seten_w0", obs[0], 32'h20);
        chk("seten_w1", obs[1], 32'h0000A5A5);
        chk("seten_done_lat", done_cyc - last_req_cyc, 1);

        // ST_DATA with source gaps
        issue(3'd2, 32'd3, 32'd1, 32'h100, 4, 0, 4'b0001, 1'b1);
        chk("stdata_nwords", obs.size(), 8);
        chk("stdata_w0", obs[0], 32'h4);
        chk("stdata_w1", obs[1], 32'h3);
        chk("stdata_w2", obs[2], 32'h1);
        chk("stdata_w3", obs[3], 32'h100);
        chk("stdata_w7", obs[7], 32'h44);
        chk("stdata_endst_word", endst_word, 32'h44);

        // LD_DATA Len=3
        issue(3'd3, 32'd9, 32'd2, 32'h200, 3, 0, 4'b0001, 1'b1);
        chk("ld_nsnk", snk_obs.size(), 3);
        chk("ld_s0", snk_obs[0], 32'h11);
        chk("ld_s1", snk_obs[1], 32'h22);
        chk("ld_s2", snk_obs[2], 32'h33);

        // ST_PROG then NoThMem
        issue(3'd1, 0, 0, 0, 2, 0, 4'b1000, 1'b0);
        chk("stprog_ready_after", O_Cmd_Ready, 1);

        // RUN timeout
        issue(3'd0, 32'h77, 0, 0, 0, 0, 4'b0000, 1'b0);
        chk("run_tmo_latency", err_cyc - last_req_cyc, 17);

        // Both NoThMem and Ready together, empty payloads, illegal ops
        issue(3'd3, 32'h1, 32'h2, 32'h3, 0, 0, 4'b1001, 1'b0);
        issue(3'd1, 0, 0, 0, 0, 0, 4'b0001, 1'b0);
        issue(3'd6, 0, 0, 0, 3, 0, 4'b0001, 1'b0);
        chk("illegal_no_words", obs.size(), 0);
        issue(3'd7, 0, 0, 0, 0, 0, 4'b0001, 1'b0);
        issue(3'd4, 0, 0, 0, 0, 0, 4'b0100, 1'b0);

        // Reset during ST_DATA payload word 2
        done_seen = 0; err_seen = 0; end_st_seen = 0; end_ld_seen = 0;
        wq.push_back(32'h4);
        wq.push_back(32'h5);
        wq.push_back(32'h6);
        wq.push_back(32'h7);
        for (int i = 0; i < 4; i++) wq.push_back(32'hA1 + i);
        I_Cmd_Valid  = 1'b1;
        I_Cmd_Op     = 3'd2;
        I_Cmd_ID     = 32'h5;
        I_Cmd_Stride = 32'h6;
        I_Cmd_Base   = 32'h7;
        I_Cmd_Len    = 16'd4;
        tick();
        I_Cmd_Valid  = 1'b0;
        send_src(32'hA1);
        I_Src_Valid = 1'b1;
        I_Src_Data  = 32'hA2;
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        chk("midrst_req", O_Req_IF, 0);
        chk("midrst_data", O_Data_IF, 0);
        chk("midrst_src_ready", O_Src_Ready, 0);
        chk("midrst_pulses", {O_End_St, O_End_Ld, O_Done, O_Err}, 0);
        chk("midrst_ready", O_Cmd_Ready, 1);
        I_Src_Valid = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        repeat (3) tick();
        chk("postrst_no_pulses", done_seen + err_seen + end_st_seen + end_ld_seen, 0);
        issue(3'd5, 0, 0, 0, 0, 16'h1234, 4'b0000, 1'b0);
        chk("postrst_seten_w1", obs[1], 32'h1234);

        // Randomised commands
        for (int n = 0; n < 30; n++) begin
            logic [3:0] st;
            st = stc[$urandom_range(0, 6)];
            issue(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 5), NT'($urandom), st, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
